// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one FSM sequences a shared ALU; 3-5 cycles per instruction plus memory wait states.
// Every memory request holds address/data stable until memready; only one access is outstanding at a time.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ALUCW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memaddr,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] memwdata,
  input  logic [31:0] memrdata,
  input  logic        memready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);
  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(4'b0000);
  localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(4'b0001);
  localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(4'b0010);
  localparam logic [ALUCW-1:0] ALU_DIV = ALUCW'(4'b0100);
  localparam logic [ALUCW-1:0] ALU_XOR = ALUCW'(4'b0101);
  localparam logic [ALUCW-1:0] ALU_NOR = ALUCW'(4'b0110);
  localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(4'b1010);
  localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(4'b1011);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] signimm, zeroimm, rs_val, rt_val;
  logic        funct_ok;

  logic [ALUCW-1:0] alu_ctrl;
  logic [31:0]      alu_a, alu_b, alu_y;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign funct    = instr_q[5:0];
  assign signimm  = {{16{instr_q[15]}}, instr_q[15:0]};
  assign zeroimm  = {16'h0000, instr_q[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];
  assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h1A};
  assign pc       = pc_q;

  // Operand selection kept apart from the FSM so the ALU result never loops back into its own select.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = pc_q;
    alu_b    = 32'd4;
    case (state_q)
      S_DECODE: alu_b = {signimm[29:0], 2'b00};
      S_MEMADR: begin
        alu_a = a_q;
        alu_b = signimm;
      end
      S_EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        case (funct)
          6'h22:   alu_ctrl = ALU_SUB;
          6'h24:   alu_ctrl = ALU_AND;
          6'h25:   alu_ctrl = ALU_OR;
          6'h26:   alu_ctrl = ALU_XOR;
          6'h27:   alu_ctrl = ALU_NOR;
          6'h2A:   alu_ctrl = ALU_SLT;
          6'h1A:   alu_ctrl = ALU_DIV;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_IEXEC: begin
        alu_a = a_q;
        case (opcode)
          OP_ANDI: begin
            alu_ctrl = ALU_AND;
            alu_b    = zeroimm;
          end
          OP_ORI: begin
            alu_ctrl = ALU_OR;
            alu_b    = zeroimm;
          end
          default: alu_b = signimm;
        endcase
      end
      S_BRANCH: begin
        alu_ctrl = ALU_SUB;
        alu_a    = a_q;
        alu_b    = b_q;
      end
      default: ;
    endcase
  end

  // Unsigned quotient; a zero divisor yields all ones.
  always_comb begin
    alu_y = 32'h0;
    case (alu_ctrl)
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_DIV: alu_y = (alu_b == 32'h0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      ALU_XOR: alu_y = alu_a ^ alu_b;
      ALU_NOR: alu_y = ~(alu_a | alu_b);
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'h0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    data_d   = data_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = aluout_q;
    memaddr  = pc_q;
    memread  = 1'b0;
    memwrite = 1'b0;
    memwdata = b_q;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        if (memready) begin
          instr_d = memrdata;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = alu_y;
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_EXEC;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
          OP_J:                     state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluout_d = alu_y;
        state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memaddr = aluout_q;
        memread = 1'b1;
        if (memready) begin
          data_d  = memrdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = data_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memaddr  = aluout_q;
        memwrite = 1'b1;
        if (memready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (funct_ok) begin
          aluout_d = alu_y;
          state_d  = S_ALUWB;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        aluout_d = alu_y;
        state_d  = S_IWB;
      end
      S_IWB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // Only beq/bne reach here: taken when beq sees equal or bne sees unequal.
        if ((opcode == OP_BEQ) == (alu_y == 32'h0)) pc_d = aluout_q;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], instr_q[25:0], 2'b00};
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      data_q   <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      aluout_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file has no reset; $0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
  end

endmodule
